// File: rtl/aes_pkg.sv
// ------------------------------------------------------------------
// aes_pkg : shared AES-128 constants, S-box, GF(2^8) helpers, FSM enum.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_for(input logic [3:0] rnd);
    int idx;
    idx = (NR - int'(rnd)) * 8;
    if (rnd >= 4'd1 && rnd <= 4'(NR)) return RCON_TABLE[idx +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_step.sv
// ------------------------------------------------------------------
// aes_key_step : one AES-128 key-expansion step (round key -> next round key).
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_out
);

  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  // RotWord then SubWord of the last word, rcon folded into the top byte.
  assign temp = sub_word({rk_in[23:0], rk_in[31:24]}) ^ {rcon, 24'h000000};

  assign w0 = rk_in[127:96] ^ temp;
  assign w1 = rk_in[95:64]  ^ w0;
  assign w2 = rk_in[63:32]  ^ w1;
  assign w3 = rk_in[31:0]   ^ w2;

  assign rk_out = {w0, w1, w2, w3};

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_core.sv
// ------------------------------------------------------------------
// aes_encrypt_core : iterative AES-128 encryptor, one round per clock.
// Build macro AES_LAST_KEY_EN adds the last_key (round-10 key) output. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_encrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
`ifdef AES_LAST_KEY_EN
  ,
  output logic [127:0] last_key
`endif
);

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte (row r, column c) sits at index r + 4c; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++) r[127-32*col -: 32] = mix_column(s[127-32*col -: 32]);
    return r;
  endfunction

  aes_state_e   state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         in_ready_q, in_ready_d;

  logic [127:0] next_rk;
  logic [127:0] sr_out;
  logic [127:0] round_out;
  logic         final_round;
  logic         accept;

  aes_key_step u_key_step (
    .rk_in  (rk_q),
    .rcon   (rcon_for(round_q)),
    .rk_out (next_rk)
  );

  assign final_round = (round_q == 4'(NR));
  assign accept      = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign sr_out      = shift_rows(sub_bytes(blk_q));
  assign round_out   = (final_round ? sr_out : mix_columns(sr_out)) ^ next_rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      blk_q      <= '0;
      rk_q       <= '0;
      round_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      rk_q       <= rk_d;
      round_q    <= round_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_RUN;
      ST_RUN:  if (final_round) state_d = ST_DONE;
      ST_DONE: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    blk_d      = blk_q;
    rk_d       = rk_q;
    round_d    = round_q;
    // Registered ready: no combinational path from out_ready to in_ready.
    in_ready_d = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          blk_d   = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
        end
      end
      ST_RUN: begin
        blk_d = round_out;
        rk_d  = next_rk;
        if (!final_round) round_d = round_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = in_ready_q;
    out_valid  = (state_q == ST_DONE);
    ciphertext = out_valid ? blk_q : '0;
`ifdef AES_LAST_KEY_EN
    last_key   = out_valid ? rk_q : '0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_core.sv
// ------------------------------------------------------------------
// tb_aes_encrypt_core : self-checking bench with a byte-level AES-128 model.
// Define AES_LAST_KEY_EN to also exercise the last_key output. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_aes_encrypt_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] ciphertext;
`ifdef AES_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
`ifdef AES_LAST_KEY_EN
    ,
    .last_key   (last_key)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  logic [7:0] sb_ref [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k,
                         output logic [127:0] ct, output logic [127:0] lk);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]], sb_ref[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_ref[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4])
                       ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic send(input logic [127:0] p, input logic [127:0] k, output bit ok);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    ok        = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (ciphertext !== '0) $display("FAIL reset_ciphertext: got %h expected 0", ciphertext); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_kat_b;
    logic [127:0] ct, lk;
    bit ok;
    int n;
    aes_ref(PT_B, KEY_B, ct, lk);
    total++; if (ct !== CT_B) $display("FAIL model_kat_b: got %h expected %h", ct, CT_B); else passed++;
    total++; if (lk !== LK_B) $display("FAIL model_lastkey_b: got %h expected %h", lk, LK_B); else passed++;
    send(PT_B, KEY_B, ok);
    total++; if (!ok) $display("FAIL kat_b_accept: got timeout expected accept"); else passed++;
    wait_out(n);
    total++; if (n != 10) $display("FAIL kat_b_latency: got %0d expected 10", n); else passed++;
    total++; if (ciphertext !== CT_B) $display("FAIL kat_b_ct: got %h expected %h", ciphertext, CT_B); else passed++;
`ifdef AES_LAST_KEY_EN
    total++; if (last_key !== LK_B) $display("FAIL kat_b_last_key: got %h expected %h", last_key, LK_B); else passed++;
`endif
    total++; if (in_ready !== 1'b0) $display("FAIL kat_b_busy_ready: got %b expected 0", in_ready); else passed++;
    drain;
    total++; if (in_ready !== 1'b1) $display("FAIL kat_b_ready_after: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_kat_c1;
    logic [127:0] ct, lk;
    bit ok;
    int n;
    aes_ref(PT_C, KEY_C, ct, lk);
    total++; if (ct !== CT_C) $display("FAIL model_kat_c1: got %h expected %h", ct, CT_C); else passed++;
    send(PT_C, KEY_C, ok);
    wait_out(n);
    total++; if (n != 10) $display("FAIL kat_c1_latency: got %0d expected 10", n); else passed++;
    total++; if (ciphertext !== CT_C) $display("FAIL kat_c1_ct: got %h expected %h", ciphertext, CT_C); else passed++;
    drain;
  endtask

  task automatic test_backpressure;
    bit ok, stable;
    int n;
    send(PT_B, KEY_B, ok);
    wait_out(n);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || ciphertext !== CT_B || in_ready !== 1'b0) stable = 1'b0;
    end
    total++; if (!stable) $display("FAIL bp_stable: got ov=%b ct=%h rdy=%b expected ov=1 ct=%h rdy=0", out_valid, ciphertext, in_ready, CT_B); else passed++;
    drain;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %b expected 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_after: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_busy_ignore;
    logic [127:0] p2, k2, ct2, lk2;
    bit ok;
    int n;
    p2 = rand128();
    k2 = rand128();
    aes_ref(p2, k2, ct2, lk2);
    send(PT_B, KEY_B, ok);
    plaintext = p2;
    key       = k2;
    in_valid  = 1'b1;
    wait_out(n);
    total++; if (ciphertext !== CT_B) $display("FAIL busy_ct: got %h expected %h", ciphertext, CT_B); else passed++;
    total++; if (n != 10) $display("FAIL busy_latency: got %0d expected 10", n); else passed++;
    drain;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(n);
    total++; if (n != 10) $display("FAIL busy_second_latency: got %0d expected 10", n); else passed++;
    total++; if (ciphertext !== ct2) $display("FAIL busy_second_ct: got %h expected %h", ciphertext, ct2); else passed++;
`ifdef AES_LAST_KEY_EN
    total++; if (last_key !== lk2) $display("FAIL busy_second_last_key: got %h expected %h", last_key, lk2); else passed++;
`endif
    drain;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    send(PT_B, KEY_B, ok);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || ciphertext !== '0 || in_ready !== 1'b0)
      $display("FAIL rst_mid_outputs: got ov=%b ct=%h rdy=%b expected 0/0/0", out_valid, ciphertext, in_ready);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(PT_C, KEY_C, ok);
    wait_out(n);
    total++; if (n != 10) $display("FAIL rst_mid_latency: got %0d expected 10", n); else passed++;
    total++; if (ciphertext !== CT_C) $display("FAIL rst_mid_ct: got %h expected %h", ciphertext, CT_C); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || ciphertext !== '0)
      $display("FAIL rst_done_outputs: got ov=%b ct=%h expected 0/0", out_valid, ciphertext);
    else passed++;
`ifdef AES_LAST_KEY_EN
    total++; if (last_key !== '0) $display("FAIL rst_done_last_key: got %h expected 0", last_key); else passed++;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int t [3];
    logic [127:0] c [3];
    int k;
    k = 0;
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        t[k] = cyc;
        c[k] = ciphertext;
        k++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (k != 3) $display("FAIL b2b_count: got %0d expected 3", k); else passed++;
    for (int j = 0; j < k; j++) begin
      total++; if (c[j] !== CT_B) $display("FAIL b2b_ct%0d: got %h expected %h", j, c[j], CT_B); else passed++;
    end
    for (int j = 1; j < k; j++) begin
      total++; if (t[j] - t[j-1] != 12) $display("FAIL b2b_interval%0d: got %0d expected 12", j, t[j] - t[j-1]); else passed++;
    end
    if (out_valid) drain;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_random;
    logic [127:0] p, k, ct, lk;
    bit ok;
    int n;
    for (int i = 0; i < 8; i++) begin
      p = rand128();
      k = rand128();
      aes_ref(p, k, ct, lk);
      send(p, k, ok);
      plaintext = rand128();
      key       = rand128();
      wait_out(n);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      total++; if (ciphertext !== ct) $display("FAIL rand%0d_ct: got %h expected %h", i, ciphertext, ct); else passed++;
`ifdef AES_LAST_KEY_EN
      total++; if (last_key !== lk) $display("FAIL rand%0d_last_key: got %h expected %h", i, last_key, lk); else passed++;
`endif
      drain;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat_b();
    test_kat_c1();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
